// File: rtl/bitstream_counter_multi.sv
// Multi-channel windowed bitstream counter: per-channel level/edge counting over a
// shared programmable window, with global/per-channel inhibit and saturating counts.
module bitstream_counter_multi #(
   parameter int P_N_CH    = 4,
   parameter int P_N_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        inh,
   input  logic [P_N_CH-1:0]           ch_inh,
   input  logic [P_N_CH-1:0]           a,
   input  logic [P_N_CH-1:0]           mode,
   input  logic [P_N_WIDTH-1:0]        period,
   output logic [P_N_CH-1:0]           y,
   output logic                        update,
   output logic                        valid,
   output logic [P_N_CH*P_N_WIDTH-1:0] n,
   output logic [P_N_CH-1:0]           ovf
);

   logic [P_N_CH-1:0]           a_q_q, a_q_d;
   logic [P_N_WIDTH-1:0]        i_cnt_q, i_cnt_d;
   logic [P_N_WIDTH-1:0]        period_l_q, period_l_d;
   logic [P_N_WIDTH-1:0]        acc_q [P_N_CH];
   logic [P_N_WIDTH-1:0]        acc_d [P_N_CH];
   logic [P_N_CH-1:0]           sat_q, sat_d;
   logic                        update_q, update_d;
   logic                        valid_q, valid_d;
   logic                        valid_0_q, valid_0_d;
   logic [P_N_CH*P_N_WIDTH-1:0] n_q, n_d;
   logic [P_N_CH-1:0]           ovf_q, ovf_d;

   logic [P_N_WIDTH-1:0]        period_eff;
   logic                        i_upd;

   always_comb begin
      period_eff = (period == '0) ? P_N_WIDTH'(1) : period;
      i_upd      = (i_cnt_q >= (period_l_q - P_N_WIDTH'(1)));

      for (int unsigned c = 0; c < P_N_CH; c++) begin
         y[c] = !inh && !ch_inh[c] && (mode[c] ? (a[c] && !a_q_q[c]) : a[c]);
      end

      a_q_d      = a;
      i_cnt_d    = i_cnt_q + P_N_WIDTH'(1);
      period_l_d = period_l_q;
      sat_d      = sat_q;
      update_d   = i_upd;
      valid_d    = valid_q;
      valid_0_d  = valid_0_q;
      n_d        = n_q;
      ovf_d      = ovf_q;
      for (int unsigned c = 0; c < P_N_CH; c++) begin
         acc_d[c] = acc_q[c];
      end

      if (i_upd) begin
         i_cnt_d    = '0;
         period_l_d = period_eff;
         valid_d    = valid_0_q;
         valid_0_d  = 1'b1;
         ovf_d      = sat_q;
      end

      // The boundary sample opens the new window; it is never a dropped sample.
      for (int unsigned c = 0; c < P_N_CH; c++) begin
         if (i_upd) begin
            n_d[c*P_N_WIDTH +: P_N_WIDTH] = acc_q[c];
            acc_d[c] = {{(P_N_WIDTH-1){1'b0}}, y[c]};
            sat_d[c] = 1'b0;
         end else if (acc_q[c] != '1) begin
            acc_d[c] = acc_q[c] + {{(P_N_WIDTH-1){1'b0}}, y[c]};
         end else if (y[c]) begin
            sat_d[c] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q_q      <= '0;
         i_cnt_q    <= '0;
         period_l_q <= period_eff;
         sat_q      <= '0;
         update_q   <= 1'b0;
         valid_q    <= 1'b0;
         valid_0_q  <= 1'b0;
         n_q        <= '0;
         ovf_q      <= '0;
         for (int unsigned c = 0; c < P_N_CH; c++) begin
            acc_q[c] <= '0;
         end
      end else begin
         a_q_q      <= a_q_d;
         i_cnt_q    <= i_cnt_d;
         period_l_q <= period_l_d;
         sat_q      <= sat_d;
         update_q   <= update_d;
         valid_q    <= valid_d;
         valid_0_q  <= valid_0_d;
         n_q        <= n_d;
         ovf_q      <= ovf_d;
         for (int unsigned c = 0; c < P_N_CH; c++) begin
            acc_q[c] <= acc_d[c];
         end
      end
   end

   assign update = update_q;
   assign valid  = valid_q;
   assign n      = n_q;
   assign ovf    = ovf_q;

endmodule
